fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit and decoder.
- Owns the PC and issues read requests to the instruction memory / icache.
- Holds one fetched instruction in an output register until decode consumes it.
- Takes PC redirects from branch/jump resolution (BEQ/BNE/J/JAL/JR) and a halt from decode; supplies instr_npc for the JAL link-register write.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  imem read complete this cycle; iload valid.
- iload  in  32  instruction word returned by imem.
- stall  in  1  decode cannot accept the instruction this cycle.
- redirect  in  1  take redirect_pc as the next fetch address.
- redirect_pc  in  32  branch/jump target.
- halt  in  1  decode has seen a HALT instruction.
- imemREN  out  1  imem read request.
- imemaddr  out  32  imem read address; always equals pc.
- instr_valid  out  1  instr, instr_pc and instr_npc hold a live instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- instr_npc  out  32  instr_pc + 4.
- halted  out  1  fetch stopped; sticky until reset.

Behaviour:
- Reset (asynchronous, RST high):
  - pc = PC_INIT; state = FETCH.
  - instr_valid = 0; instr = 0; instr_pc = 0; instr_npc = 0; halted = 0.
  - imemREN = 0 while RST is high.
- States:
  - FETCH: normal fetching.
  - HALTED: absorbing; left only by reset.
- imemREN is combinational: imemREN = (state==FETCH) && !RST && !(instr_valid && stall).
  - No new request is made while a held instruction is stalled.
- Handshakes:
  - Consume: decode takes the instruction on any cycle with instr_valid=1 and stall=0.
  - Accept: a fetch is accepted on a cycle with imemREN=1, ihit=1, redirect=0, halt=0.
- On an accepted fetch, at the next edge:
  - instr <= iload; instr_pc <= pc; instr_npc <= pc+4.
  - instr_valid <= 1; pc <= pc+4.
- Consumed with no accepted fetch in the same cycle: instr_valid <= 0 at the next edge.
- Consume and accept in the same cycle: the output register is overwritten and instr_valid stays 1. This gives 1 instruction/cycle throughput when ihit is continuous.
- Fetch latency: an ihit in cycle N gives instr_valid=1 in cycle N+1.
- Redirect (priority over ihit, stall and consume):
  - pc <= {redirect_pc[31:2], 2'b00}; instr_valid <= 0 (squash).
  - Any ihit in the same cycle is discarded.
  - Redirect while stalled is still taken and flushes the held instruction.
- Halt (priority over redirect and ihit):
  - state <= HALTED; halted <= 1; instr_valid <= 0.
  - pc is frozen and imemREN = 0 from the next cycle onward.
  - All inputs are ignored in HALTED.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFFFFFC + 4 = 32'h00000000. instr_npc wraps the same way.
- A reset asserted mid-request abandons the request. The first fetch after RST deasserts is to PC_INIT; any late ihit from the abandoned request before that fetch is ignored because imemREN=0.
- Unchanged registers hold their value on every non-listed cycle. There are no X outputs after reset.

Test Plan:
- Reset, then ihit=1 for 3 cycles returning words A, B, C with stall=0 -> imemaddr 0, 4, 8; instr A/B/C with instr_pc 0/4/8 and instr_npc 4/8/12 on successive cycles.
- Fetch A at 0, then stall=1 for 3 cycles with ihit held at 1 -> imemREN=0 during the stall; instr=A held; pc=4. On stall release, the fetch at 4 resumes.
- redirect=1, redirect_pc=32'h00000103, together with ihit=1 -> the ihit word is dropped; instr_valid=0 the next cycle; the next imemaddr is 32'h00000100.
- halt=1 and redirect=1 in the same cycle -> halted=1, imemREN=0, pc unchanged, instr_valid=0. Later ihit/redirect pulses cause no change until RST.
- PC_INIT=32'hFFFFFFFC, one ihit -> instr_pc=32'hFFFFFFFC, instr_npc=0, next imemaddr=0.
- RST asserted mid-stream with instr_valid=1 -> all outputs clear immediately (asynchronously); imemREN=0 during reset; after release, imemaddr=PC_INIT.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from imem and holds one
// fetched instruction until decode consumes it. Handles redirects and halt.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc,
  output logic        halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] inpc_q, inpc_d;
  logic        valid_q, valid_d;
  logic        accept;
  logic        consume;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // FSM next state: HALTED is absorbing until reset
  always_comb begin
    state_d = state_q;
    if (state_q == FETCH && halt) state_d = HALTED;
  end

  // FSM outputs
  always_comb begin
    imemREN = 1'b0;
    halted  = 1'b0;
    if (state_q == FETCH) imemREN = !RST && !(valid_q && stall);
    else                  halted  = 1'b1;
  end

  assign accept  = imemREN && ihit && !redirect && !halt;
  assign consume = valid_q && !stall;

  // Datapath: halt > redirect > accepted fetch > consume
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    inpc_d  = inpc_q;
    valid_d = valid_q;
    if (state_q == FETCH) begin
      if (halt) begin
        valid_d = 1'b0;
      end else if (redirect) begin
        pc_d    = redirect_pc & 32'hFFFF_FFFC;
        valid_d = 1'b0;
      end else if (accept) begin
        instr_d = iload;
        ipc_d   = pc_q;
        inpc_d  = pc_q + 32'd4;
        pc_d    = pc_q + 32'd4;
        valid_d = 1'b1;
      end else if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= PC_INIT;
      instr_q <= '0;
      ipc_q   <= '0;
      inpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      inpc_q  <= inpc_d;
      valid_q <= valid_d;
    end
  end

  assign imemaddr    = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_npc   = inpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model checked every cycle plus
// hand-computed literal expectations at key points of each scenario.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        imemREN, instr_valid, halted;
  logic [31:0] imemaddr, instr, instr_pc, instr_npc;

  // second instance exercising the PC wrap boundary
  logic        RST2 = 1'b1;
  logic        ihit2 = 1'b0;
  logic [31:0] iload2 = '0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic        imemREN2, instr_valid2, halted2;
  logic [31:0] imemaddr2, instr2, instr_pc2, instr_npc2;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_npc(instr_npc), .halted(halted)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(RST2), .ihit(ihit2), .iload(iload2), .stall(zero1),
    .redirect(zero1), .redirect_pc(zero32), .halt(zero1),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .instr_valid(instr_valid2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_npc(instr_npc2), .halted(halted2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what decode should see, derived from the handshake rules
  logic [31:0] m_pc, m_instr, m_ipc, m_npc;
  logic        m_valid, m_halt;
  bit          m_can_req;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc = 32'h0; m_instr = '0; m_ipc = '0; m_npc = '0;
      m_valid = 1'b0; m_halt = 1'b0;
    end else if (!m_halt) begin
      m_can_req = !(m_valid && stall);
      if (halt) begin
        m_halt = 1'b1; m_valid = 1'b0;
      end else if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 1'b0;
      end else if (m_can_req && ihit) begin
        m_instr = iload; m_ipc = m_pc; m_npc = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end else begin
        m_valid = m_valid && stall;  // held only while decode stalls
      end
    end
  end

  always @(negedge CLK) begin
    if ($time > 10) begin
      check("m_imemREN", {31'b0, imemREN}, {31'b0, !RST && !m_halt && !(m_valid && stall)});
      check("m_imemaddr", imemaddr, m_pc);
      check("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("m_instr", instr, m_instr);
      check("m_instr_pc", instr_pc, m_ipc);
      check("m_instr_npc", instr_npc, m_npc);
      check("m_halted", {31'b0, halted}, {31'b0, m_halt});
    end
  end

  // drive inputs just after an edge, then advance one full cycle
  task automatic cyc(input logic h, input logic [31:0] w, input logic s,
                     input logic r, input logic [31:0] rpc, input logic hl);
    ihit = h; iload = w; stall = s; redirect = r; redirect_pc = rpc; halt = hl;
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; idle_inputs();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_imemREN", {31'b0, imemREN}, 32'd0);
    check("rst_addr", imemaddr, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    RST = 1'b0;

    // back-to-back fetches A, B, C
    cyc(1, 32'hAAAA_0001, 0, 0, 0, 0);
    check("t1_instrA", instr, 32'hAAAA_0001);
    check("t1_npcA", instr_npc, 32'd4);
    cyc(1, 32'hBBBB_0002, 0, 0, 0, 0);
    check("t1_instrB", instr, 32'hBBBB_0002);
    check("t1_pcB", instr_pc, 32'd4);
    cyc(1, 32'hCCCC_0003, 0, 0, 0, 0);
    check("t1_pcC", instr_pc, 32'd8);
    check("t1_npcC", instr_npc, 32'd12);
    check("t1_addr", imemaddr, 32'd12);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_consumed", {31'b0, instr_valid}, 32'd0);

    // stall holds A and blocks requests
    do_reset();
    cyc(1, 32'hAAAA_0001, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      ihit = 1'b1; iload = 32'hDEAD_0000 + i; stall = 1'b1; #1;
      check("t2_ren_stall", {31'b0, imemREN}, 32'd0);
      @(posedge CLK); #1;
      check("t2_hold", instr, 32'hAAAA_0001);
      check("t2_pc", imemaddr, 32'd4);
    end
    cyc(1, 32'hBBBB_0002, 0, 0, 0, 0);
    check("t2_resume", instr_pc, 32'd4);
    check("t2_resumeB", instr, 32'hBBBB_0002);

    // redirect drops the concurrent ihit and aligns the target
    cyc(1, 32'hDDDD_0004, 0, 1, 32'h0000_0103, 0);
    check("t3_squash", {31'b0, instr_valid}, 32'd0);
    check("t3_addr", imemaddr, 32'h0000_0100);
    cyc(1, 32'hEEEE_0005, 0, 0, 0, 0);
    check("t3_pc", instr_pc, 32'h0000_0100);
    check("t3_npc", instr_npc, 32'h0000_0104);
    cyc(0, 0, 1, 1, 32'h0000_0202, 0);
    check("t3_stall_redir", {31'b0, instr_valid}, 32'd0);
    check("t3_stall_addr", imemaddr, 32'h0000_0200);

    // halt beats redirect; everything frozen afterwards
    cyc(1, 32'hFFFF_0006, 0, 0, 0, 0);
    cyc(1, 32'h1111_0007, 0, 1, 32'h0000_0300, 1);
    check("t4_halted", {31'b0, halted}, 32'd1);
    check("t4_addr", imemaddr, 32'h0000_0204);
    check("t4_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1, 32'h2222_0008, 0, 1, 32'h0000_0400, 0);
    cyc(1, 32'h3333_0009, 0, 0, 0, 0);
    check("t4_frozen", imemaddr, 32'h0000_0204);
    check("t4_ren", {31'b0, imemREN}, 32'd0);
    check("t4_instr", instr, 32'hFFFF_0006);

    // asynchronous reset mid-stream, late ihit ignored
    do_reset();
    cyc(1, 32'h4444_000A, 0, 0, 0, 0);
    check("t6_pre_valid", {31'b0, instr_valid}, 32'd1);
    ihit = 1'b1; iload = 32'h5555_000B;
    #1 RST = 1'b1;
    #1;
    check("t6_async_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_async_instr", instr, 32'd0);
    check("t6_async_npc", instr_npc, 32'd0);
    check("t6_async_ren", {31'b0, imemREN}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; ihit = 1'b0;
    check("t6_addr", imemaddr, 32'd0);
    cyc(1, 32'h6666_000C, 0, 0, 0, 0);
    check("t6_first", instr_pc, 32'd0);
    check("t6_firstw", instr, 32'h6666_000C);
    cyc(0, 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    RST2 = 1'b0;
    check("t5_addr0", imemaddr2, 32'hFFFF_FFFC);
    ihit2 = 1'b1; iload2 = 32'h7777_000D;
    @(posedge CLK); #1;
    ihit2 = 1'b0;
    check("t5_pc", instr_pc2, 32'hFFFF_FFFC);
    check("t5_npc", instr_npc2, 32'h0000_0000);
    check("t5_addr", imemaddr2, 32'h0000_0000);
    check("t5_valid", {31'b0, instr_valid2}, 32'd1);

    repeat (2) @(posedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
